// File: rtl/infix_tokenizer_if.sv
`default_nettype none
// ============================================================================
// Module   : infix_tokenizer_if
// Brief    : Character input and STB/ACK token output bundle of the tokenizer.
// Revision : 1.0
// ============================================================================
interface infix_tokenizer_if #(
    parameter int WIDTH = 8
);
    logic [7:0]       CHAR;
    logic             CHAR_STB;
    logic             CHAR_ACK;
    logic [7:0]       SIGN_OUT;
    logic             SIGN_OUT_STB;
    logic             SIGN_OUT_ACK;
    logic [WIDTH-1:0] NUMBER_OUT;
    logic             NUMBER_OUT_STB;
    logic             NUMBER_OUT_ACK;
    logic             OVERFLOW;
    logic             ERROR;

    modport master (
        input  CHAR, CHAR_STB, SIGN_OUT_ACK, NUMBER_OUT_ACK,
        output CHAR_ACK, SIGN_OUT, SIGN_OUT_STB, NUMBER_OUT, NUMBER_OUT_STB,
               OVERFLOW, ERROR
    );

    modport slave (
        output CHAR, CHAR_STB, SIGN_OUT_ACK, NUMBER_OUT_ACK,
        input  CHAR_ACK, SIGN_OUT, SIGN_OUT_STB, NUMBER_OUT, NUMBER_OUT_STB,
               OVERFLOW, ERROR
    );
endinterface
`default_nettype wire

// File: rtl/infix_tokenizer.sv
`default_nettype none
// ============================================================================
// Module   : infix_tokenizer
// Brief    : Folds an ASCII infix stream into number/operator STB/ACK tokens.
// Revision : 1.0
// ============================================================================
module infix_tokenizer #(
    parameter int WIDTH = 8
) (
    input  logic              CLK,
    input  logic              RST,
    infix_tokenizer_if.master tok
);

    localparam int               c_AW  = WIDTH + 4;
    localparam logic [WIDTH-1:0] c_MAX = {WIDTH{1'b1}};

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_NUM       = 3'd1;
    localparam logic [2:0] c_EMIT_NUM  = 3'd2;
    localparam logic [2:0] c_EMIT_SIGN = 3'd3;
    localparam logic [2:0] c_EMIT_END  = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       r_after;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_num_out;
    logic [7:0]       r_sign_out;
    logic             r_char_ack;
    logic             r_sign_stb;
    logic             r_num_stb;
    logic             r_overflow;
    logic             r_error;

    logic [2:0]       w_nxt;
    logic             w_take;
    logic             w_is_digit;
    logic             w_is_op;
    logic             w_is_ws;
    logic             w_is_end;
    logic [c_AW-1:0]  w_ext;
    logic [c_AW-1:0]  w_sum;
    logic             w_sat;

    assign w_take     = tok.CHAR_STB & r_char_ack;
    assign w_is_digit = (tok.CHAR >= 8'h30) && (tok.CHAR <= 8'h39);
    assign w_is_op    = (tok.CHAR == 8'h2B) || (tok.CHAR == 8'h2D) ||
                        (tok.CHAR == 8'h2A) || (tok.CHAR == 8'h2F);
    assign w_is_ws    = (tok.CHAR == 8'h20) || (tok.CHAR == 8'h0D);
    assign w_is_end   = (tok.CHAR == 8'h0A) || (tok.CHAR == 8'h3B);

    // acc*10 as shifts; ASCII digits carry their value in the low nibble
    assign w_ext = {4'b0000, r_acc};
    assign w_sum = (w_ext << 3) + (w_ext << 1) + {{WIDTH{1'b0}}, tok.CHAR[3:0]};
    assign w_sat = |w_sum[c_AW-1:WIDTH];

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            c_IDLE, c_NUM: begin
                if (w_take) begin
                    if (w_is_digit)
                        w_nxt = c_NUM;
                    else if (r_state == c_NUM)
                        w_nxt = c_EMIT_NUM;
                    else if (w_is_op)
                        w_nxt = c_EMIT_SIGN;
                    else if (w_is_end)
                        w_nxt = c_EMIT_END;
                    else
                        w_nxt = c_IDLE;
                end
            end
            c_EMIT_NUM:  if (tok.NUMBER_OUT_ACK) w_nxt = r_after;
            c_EMIT_SIGN: if (tok.SIGN_OUT_ACK)   w_nxt = c_IDLE;
            c_EMIT_END: begin
                if (!(r_sign_stb && !tok.SIGN_OUT_ACK) && !(r_num_stb && !tok.NUMBER_OUT_ACK))
                    w_nxt = c_IDLE;
            end
            default: w_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= c_IDLE;
            r_after    <= c_IDLE;
            r_acc      <= '0;
            r_num_out  <= '0;
            r_sign_out <= '0;
            r_char_ack <= 1'b0;
            r_sign_stb <= 1'b0;
            r_num_stb  <= 1'b0;
            r_overflow <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_nxt;
            r_char_ack <= (w_nxt == c_IDLE) || (w_nxt == c_NUM);
            case (r_state)
                c_IDLE, c_NUM: begin
                    if (w_take) begin
                        if (w_is_digit) begin
                            r_acc <= w_sat ? c_MAX : w_sum[WIDTH-1:0];
                            if (w_sat)
                                r_overflow <= 1'b1;
                        end else begin
                            // any non-digit terminates a pending number
                            if (r_state == c_NUM) begin
                                r_num_out <= r_acc;
                                r_num_stb <= 1'b1;
                                r_acc     <= '0;
                            end
                            if (w_is_op) begin
                                r_sign_out <= tok.CHAR;
                                r_after    <= c_EMIT_SIGN;
                                if (r_state == c_IDLE)
                                    r_sign_stb <= 1'b1;
                            end else if (w_is_end) begin
                                r_after <= c_EMIT_END;
                                if (r_state == c_IDLE) begin
                                    r_sign_out <= '0;
                                    r_num_out  <= '0;
                                    r_sign_stb <= 1'b1;
                                    r_num_stb  <= 1'b1;
                                end
                            end else begin
                                r_after <= c_IDLE;
                                if (!w_is_ws)
                                    r_error <= 1'b1;
                            end
                        end
                    end
                end
                c_EMIT_NUM: begin
                    if (tok.NUMBER_OUT_ACK) begin
                        r_num_stb <= 1'b0;
                        if (r_after == c_EMIT_SIGN)
                            r_sign_stb <= 1'b1;
                        if (r_after == c_EMIT_END) begin
                            r_sign_out <= '0;
                            r_num_out  <= '0;
                            r_sign_stb <= 1'b1;
                            r_num_stb  <= 1'b1;
                        end
                    end
                end
                c_EMIT_SIGN: begin
                    if (tok.SIGN_OUT_ACK)
                        r_sign_stb <= 1'b0;
                end
                c_EMIT_END: begin
                    if (tok.SIGN_OUT_ACK)
                        r_sign_stb <= 1'b0;
                    if (tok.NUMBER_OUT_ACK)
                        r_num_stb <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign tok.CHAR_ACK       = r_char_ack;
    assign tok.SIGN_OUT       = r_sign_out;
    assign tok.SIGN_OUT_STB   = r_sign_stb;
    assign tok.NUMBER_OUT     = r_num_out;
    assign tok.NUMBER_OUT_STB = r_num_stb;
    assign tok.OVERFLOW       = r_overflow;
    assign tok.ERROR          = r_error;

endmodule
`default_nettype wire

// File: tb/tb_infix_tokenizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_infix_tokenizer
// Brief    : Directed and randomized checking of infix_tokenizer against a token-queue model.
// Revision : 1.0
// ============================================================================
module tb_infix_tokenizer;

    localparam int WIDTH  = 8;
    localparam int MAXV   = (1 << WIDTH) - 1;
    localparam int K_NUM  = 0;
    localparam int K_SIGN = 1;
    localparam int K_END  = 2;

    typedef struct {
        int kind;
        int val;
    } tok_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    infix_tokenizer_if #(.WIDTH(WIDTH)) bus();

    infix_tokenizer #(.WIDTH(WIDTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .tok (bus)
    );

    always #5 CLK = ~CLK;

    int   checks = 0;
    int   errors = 0;

    logic manual     = 1'b0;
    logic m_sign_ack = 1'b1;
    logic m_num_ack  = 1'b1;
    logic rand_ack   = 1'b0;
    logic gap_en     = 1'b0;
    logic rnd_sign_ack = 1'b1;
    logic rnd_num_ack  = 1'b1;

    assign bus.SIGN_OUT_ACK   = manual ? m_sign_ack : rnd_sign_ack;
    assign bus.NUMBER_OUT_ACK = manual ? m_num_ack  : rnd_num_ack;

    always @(posedge CLK) begin
        #1;
        rnd_sign_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
        rnd_num_ack  = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Model state: expected tokens in arrival order
    tok_t  exp_q[$];
    int    macc    = 0;
    bit    in_run  = 0;
    bit    exp_ovf = 0;
    bit    exp_err = 0;
    bit    in_end  = 0;
    string log_s   = "";
    int    post_rst = 0;

    logic       sstb, nstb;
    logic       p_sstb = 0, p_sack = 0, p_nstb = 0, p_nack = 0;
    logic [7:0] p_sval = 0;
    logic [WIDTH-1:0] p_nval = 0;

    always @(posedge CLK or negedge RST) begin
        if (!RST)
            post_rst = 0;
        else if (post_rst < 2)
            post_rst = post_rst + 1;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual \"%s\" required \"%s\"", name, act, req);
        end
    endtask

    task automatic pop_expect(input int kind, input int val);
        tok_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL token_unexpected actual kind %0d value %0d required none", kind, val);
        end else begin
            e = exp_q.pop_front();
            chk("token_kind", kind, e.kind);
            chk("token_value", val, e.val);
        end
    endtask

    task automatic model_char(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) begin
            macc = macc * 10 + (int'(c) - 48);
            if (macc > MAXV) begin
                macc    = MAXV;
                exp_ovf = 1;
            end
            in_run = 1;
        end else begin
            if (in_run) begin
                exp_q.push_back('{K_NUM, macc});
                macc   = 0;
                in_run = 0;
            end
            if (c == "+" || c == "-" || c == "*" || c == "/")
                exp_q.push_back('{K_SIGN, int'(c)});
            else if (c == 8'h0A || c == ";")
                exp_q.push_back('{K_END, 0});
            else if (c != 8'h20 && c != 8'h0D)
                exp_err = 1;
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            chk("reset_outputs", int'({bus.CHAR_ACK, bus.SIGN_OUT_STB, bus.NUMBER_OUT_STB,
                                       bus.OVERFLOW, bus.ERROR, |bus.SIGN_OUT, |bus.NUMBER_OUT}), 0);
            exp_q.delete();
            macc = 0; in_run = 0; exp_ovf = 0; exp_err = 0; in_end = 0;
            p_sstb = 0; p_nstb = 0;
        end else begin
            sstb = bus.SIGN_OUT_STB;
            nstb = bus.NUMBER_OUT_STB;
            chk("overflow", bus.OVERFLOW, exp_ovf);
            chk("error", bus.ERROR, exp_err);
            if (post_rst >= 1)
                chk("char_ack", bus.CHAR_ACK, !(sstb || nstb));
            if (p_nstb && !p_nack) begin
                chk("num_hold_stb", nstb, 1);
                chk("num_hold_val", bus.NUMBER_OUT, p_nval);
            end
            if (p_sstb && !p_sack) begin
                chk("sign_hold_stb", sstb, 1);
                chk("sign_hold_val", bus.SIGN_OUT, p_sval);
            end
            if (in_end && !sstb && !nstb)
                in_end = 0;
            if (sstb && nstb && !in_end) begin
                pop_expect(K_END, 0);
                log_s  = {log_s, "E "};
                in_end = 1;
            end
            if (in_end) begin
                if (sstb) chk("end_sign_zero", bus.SIGN_OUT, 0);
                if (nstb) chk("end_num_zero", bus.NUMBER_OUT, 0);
            end else begin
                if (nstb && bus.NUMBER_OUT_ACK) begin
                    pop_expect(K_NUM, bus.NUMBER_OUT);
                    log_s = $sformatf("%sN%0d ", log_s, bus.NUMBER_OUT);
                end
                if (sstb && bus.SIGN_OUT_ACK) begin
                    pop_expect(K_SIGN, bus.SIGN_OUT);
                    log_s = $sformatf("%sS%c ", log_s, bus.SIGN_OUT);
                end
            end
            if (bus.CHAR_STB && bus.CHAR_ACK)
                model_char(bus.CHAR);
            p_sstb = sstb; p_sack = bus.SIGN_OUT_ACK; p_sval = bus.SIGN_OUT;
            p_nstb = nstb; p_nack = bus.NUMBER_OUT_ACK; p_nval = bus.NUMBER_OUT;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge
    task automatic send_char(input logic [7:0] c);
        int n = 0;
        bus.CHAR     = c;
        bus.CHAR_STB = 1'b1;
        do begin
            @(negedge CLK);
            n++;
        end while (!bus.CHAR_ACK && n < 1000);
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL char_accept_timeout actual no CHAR_ACK required CHAR_ACK within 1000 cycles");
        end
        @(posedge CLK);
        #1;
        bus.CHAR_STB = 1'b0;
    endtask

    task automatic send_str(input string s);
        int k;
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i]);
            k = $urandom_range(0, 2);
            if (gap_en && k > 0) begin
                repeat (k) @(posedge CLK);
                #1;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 500 && !(exp_q.size() == 0 && !bus.SIGN_OUT_STB &&
                            !bus.NUMBER_OUT_STB && bus.CHAR_ACK)) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual %0d tokens pending required 0", exp_q.size());
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic run_str(input string s, input string req_log);
        log_s = "";
        send_str(s);
        wait_idle();
        chk_str("token_log", log_s, req_log);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual still running required finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        string s;
        int    r;
        int    n;
        logic [7:0] ch;
        bus.CHAR     = 8'h00;
        bus.CHAR_STB = 1'b0;
        #1 RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        chk("char_ack_before_edge", bus.CHAR_ACK, 0);
        @(posedge CLK);
        #1;
        chk("char_ack_after_reset", bus.CHAR_ACK, 1);

        run_str("12+3\n", "N12 S+ N3 E ");
        run_str("300*2\n", "N255 S* N2 E ");
        chk("overflow_set", bus.OVERFLOW, 1);
        run_str(" 7  -  8 ;", "N7 S- N8 E ");
        chk("overflow_sticky", bus.OVERFLOW, 1);
        chk("error_clear_spaces", bus.ERROR, 0);
        run_str("4x5\n", "N4 N5 E ");
        chk("error_set", bus.ERROR, 1);

        // Number held un-ACKed for five cycles
        log_s      = "";
        manual     = 1'b1;
        m_sign_ack = 1'b1;
        m_num_ack  = 1'b0;
        fork
            send_str("9/3\n");
            begin
                n = 0;
                do begin @(negedge CLK); n++; end while (!bus.NUMBER_OUT_STB && n < 100);
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge CLK);
                    chk("hold9_stb", bus.NUMBER_OUT_STB, 1);
                    chk("hold9_val", bus.NUMBER_OUT, 9);
                    chk("hold9_char_ack", bus.CHAR_ACK, 0);
                    chk("hold9_no_sign", bus.SIGN_OUT_STB, 0);
                end
                @(posedge CLK);
                #1 m_num_ack = 1'b1;
            end
        join
        wait_idle();
        chk_str("token_log", log_s, "N9 S/ N3 E ");

        // End marker with ACKs in different cycles
        log_s      = "";
        m_sign_ack = 1'b0;
        m_num_ack  = 1'b0;
        fork
            send_str(";");
            begin
                n = 0;
                do begin @(negedge CLK); n++; end while (!(bus.SIGN_OUT_STB && bus.NUMBER_OUT_STB) && n < 100);
                chk("end_both_high", int'({bus.SIGN_OUT_STB, bus.NUMBER_OUT_STB}), 3);
                @(posedge CLK); #1 m_sign_ack = 1'b1;
                @(posedge CLK); #1 m_sign_ack = 1'b0;
                repeat (2) begin
                    @(negedge CLK);
                    chk("end_stagger_sign", bus.SIGN_OUT_STB, 0);
                    chk("end_stagger_num", bus.NUMBER_OUT_STB, 1);
                    @(posedge CLK);
                    #1;
                end
                m_num_ack = 1'b1;
                @(negedge CLK);
                chk("end_stagger_num_last", bus.NUMBER_OUT_STB, 1);
                @(posedge CLK); #1 m_num_ack = 1'b0;
                @(negedge CLK);
                chk("end_stagger_num_drop", bus.NUMBER_OUT_STB, 0);
            end
        join
        manual = 1'b0;
        wait_idle();
        chk_str("token_log", log_s, "E ");

        // Reset in the middle of "56+"
        log_s = "";
        send_char("5");
        send_char("6");
        #2 RST = 1'b0;
        #1;
        chk("async_reset_clear", int'({bus.CHAR_ACK, bus.SIGN_OUT_STB, bus.NUMBER_OUT_STB,
                                       bus.OVERFLOW, bus.ERROR}), 0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1;
        chk_str("no_token_after_reset", log_s, "");
        run_str("+\n", "S+ E ");
        chk("overflow_after_reset", bus.OVERFLOW, 0);
        chk("error_after_reset", bus.ERROR, 0);

        // Randomized expressions with random ACK back-pressure and input gaps
        rand_ack = 1'b1;
        gap_en   = 1'b1;
        for (int t = 0; t < 40; t++) begin
            s = "";
            n = $urandom_range(1, 14);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 99);
                if (r < 55)      ch = 8'(48 + $urandom_range(0, 9));
                else if (r < 70) begin
                    case ($urandom_range(0, 3))
                        0: ch = "+";
                        1: ch = "-";
                        2: ch = "*";
                        default: ch = "/";
                    endcase
                end
                else if (r < 82) ch = ($urandom_range(0, 1) == 0) ? 8'h20 : 8'h0D;
                else if (r < 88) ch = ($urandom_range(0, 1) == 0) ? "x" : "(";
                else             ch = ($urandom_range(0, 1) == 0) ? 8'h0A : ";";
                s = $sformatf("%s%c", s, ch);
            end
            s = {s, "\n"};
            log_s = "";
            send_str(s);
            wait_idle();
        end
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
